// File: rtl/seq_rotate_left_right_pkg.sv
// Shared definitions for the sequential rotator: FSM state encodings used by
// both the RTL and its bench.
package seq_rotate_left_right_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_rotate_left_right_if.sv
// Request/result handshake bundle of the sequential rotator.
interface seq_rotate_left_right_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_A;
    logic [SHW-1:0]   i_k;
    logic             i_left;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_Y;
    logic             o_busy;

    modport master (
        output i_valid, i_A, i_k, i_left, i_ready,
        input  o_ready, o_valid, o_Y, o_busy
    );

    modport slave (
        input  i_valid, i_A, i_k, i_left, i_ready,
        output o_ready, o_valid, o_Y, o_busy
    );
endinterface

// File: rtl/rotate_step.sv
// Combinational single-position rotate; left moves the MSB into the LSB,
// right moves the LSB into the MSB.
module rotate_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic             left,
    output logic [WIDTH-1:0] dout
);

    // one-position rotate in the requested direction
    always_comb begin
        dout = din;
        if (left) begin
            dout = {din[WIDTH-2:0], din[WIDTH-1]};
        end else begin
            dout = {din[0], din[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_rotate_left_right.sv
// Multi-cycle rotator: captures an operand and rotates it one bit per cycle
// until the requested amount is reached, then holds the result for the consumer.
module seq_rotate_left_right
    import seq_rotate_left_right_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    seq_rotate_left_right_if.slave  bus
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SHW-1:0]   cnt_r;
    logic [SHW-1:0]   cnt_nxt_s;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_nxt_s;
    logic [WIDTH-1:0] rot_s;
    logic             left_r;
    logic             left_nxt_s;
    logic             ready_r;
    logic             valid_r;
    logic             busy_r;

    rotate_step #(.WIDTH(WIDTH)) u_rotate_step (
        .din  (work_r),
        .left (left_r),
        .dout (rot_s)
    );

    // next-state, counter and working-register selection
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        work_nxt_s  = work_r;
        left_nxt_s  = left_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    work_nxt_s = bus.i_A;
                    left_nxt_s = bus.i_left;
                    cnt_nxt_s  = bus.i_k;
                    if (bus.i_k == {SHW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_nxt_s = rot_s;
                cnt_nxt_s  = cnt_r - SHW'(1);
                // the last rotate step lands together with the move to DONE
                if (cnt_r == SHW'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {SHW{1'b0}};
            end
        endcase
    end

    // state, datapath and registered handshake flags
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {SHW{1'b0}};
            work_r  <= {WIDTH{1'b0}};
            left_r  <= 1'b0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            work_r  <= work_nxt_s;
            left_r  <= left_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            valid_r <= (state_nxt_s == ST_DONE);
            busy_r  <= (state_nxt_s == ST_SHIFT);
        end
    end

    assign bus.o_ready = ready_r;
    assign bus.o_valid = valid_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_Y     = work_r;

endmodule
